// File: rtl/rot_pkg.sv
// Shared definitions for the rotary encoder front end: quadrature Gray states,
// direction constants and the position update helper.
package rot_pkg;

  typedef enum logic [1:0] {
    QS_00 = 2'b00,
    QS_01 = 2'b01,
    QS_11 = 2'b11,
    QS_10 = 2'b10
  } quad_state_t;

  localparam logic DIR_CW  = 1'b1;
  localparam logic DIR_CCW = 1'b0;

  // Gray AB to a 0..3 phase index so that one CW quarter is always +1 mod 4.
  function automatic logic [1:0] quad_index(input logic [1:0] ab);
    return {ab[1], ab[1] ^ ab[0]};
  endfunction

  function automatic int next_pos(input int pos, input logic dir, input int delta,
                                  input int n, input logic wrap);
    int p;
    p = (dir == DIR_CW) ? pos + delta : pos - delta;
    if (wrap) begin
      p = p % n;
      if (p < 0) p = p + n;
    end else begin
      if (p > n - 1) p = n - 1;
      if (p < 0) p = 0;
    end
    return p;
  endfunction

endpackage

// File: rtl/rot_chan_filter.sv
// One encoder channel: two-flop synchroniser followed by a debounce filter that
// accepts a new level only after DEB_CYCLES consecutive differing samples.
module rot_chan_filter #(
  parameter int DEB_CYCLES = 4
) (
  input  logic clk,
  input  logic nrst,
  input  logic i_raw,
  output logic o_filt
);

  localparam int CNT_W = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEB_CYCLES - 1);

  logic             r_s1;
  logic             r_s2;
  logic             r_filt;
  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_s1   <= 1'b0;
      r_s2   <= 1'b0;
      r_filt <= 1'b0;
      r_cnt  <= '0;
    end else begin
      r_s1 <= i_raw;
      r_s2 <= r_s1;
      if (r_s2 != r_filt) begin
        if (r_cnt == CNT_LAST) begin
          r_filt <= r_s2;
          r_cnt  <= '0;
        end else begin
          r_cnt <= r_cnt + CNT_W'(1);
        end
      end else begin
        r_cnt <= '0;
      end
    end
  end

  assign o_filt = r_filt;

endmodule

// File: rtl/rot_position_bar.sv
// Rotary encoder to LED position display: filtered 4x quadrature decode, detent
// accumulator, position counter and dot/bar display. Optional ROT_ACCEL_EN adds
// a double-step when detents follow each other within ACCEL_WIN cycles.
module rot_position_bar
  import rot_pkg::*;
#(
  parameter int N_LEDS        = 8,
  parameter int DEB_CYCLES    = 4,
  parameter int STEP_QUARTERS = 4,
  parameter int WRAP          = 1,
  parameter int MODE          = 0,
  parameter int ACCEL_WIN     = 64
) (
  input  logic                      clk,
  input  logic                      nrst,
  input  logic                      rotA,
  input  logic                      rotB,
  output logic [N_LEDS-1:0]         light,
  output logic [$clog2(N_LEDS)-1:0] pos,
  output logic                      step_valid,
  output logic                      step_dir,
  output logic                      quad_err
);

  localparam int POS_W = $clog2(N_LEDS);
  localparam int ACC_W = $clog2(STEP_QUARTERS) + 2;
  localparam logic signed [ACC_W-1:0] ACC_ONE = ACC_W'(1);
  localparam logic signed [ACC_W-1:0] ACC_MAX = ACC_W'(STEP_QUARTERS);
  localparam logic signed [ACC_W-1:0] ACC_MIN = -ACC_MAX;

  if (N_LEDS < 2 || DEB_CYCLES < 1 || ACCEL_WIN < 1 ||
      !(STEP_QUARTERS == 1 || STEP_QUARTERS == 2 || STEP_QUARTERS == 4)) begin : g_param_err
    $error("rot_position_bar: illegal parameter set");
  end

  logic                    w_fa;
  logic                    w_fb;
  logic [1:0]              w_ab;
  logic [1:0]              w_dq;
  quad_state_t             r_ab_prev;
  logic signed [ACC_W-1:0] r_acc;
  logic signed [ACC_W-1:0] w_acc_inc;
  logic signed [ACC_W-1:0] w_acc_dec;
  logic signed [ACC_W-1:0] w_acc_next;
  logic                    w_step;
  logic                    w_dir;
  logic                    w_err;
  logic [1:0]              w_delta;
  logic [POS_W-1:0]        w_pos_next;
  logic [N_LEDS-1:0]       w_light;

  rot_chan_filter #(.DEB_CYCLES(DEB_CYCLES)) u_filt_a (
    .clk(clk), .nrst(nrst), .i_raw(rotA), .o_filt(w_fa)
  );

  rot_chan_filter #(.DEB_CYCLES(DEB_CYCLES)) u_filt_b (
    .clk(clk), .nrst(nrst), .i_raw(rotB), .o_filt(w_fb)
  );

  assign w_ab      = {w_fa, w_fb};
  assign w_dq      = quad_index(w_ab) - quad_index(r_ab_prev);
  assign w_acc_inc = r_acc + ACC_ONE;
  assign w_acc_dec = r_acc - ACC_ONE;

  // Phase delta 1 = CW quarter, 3 = CCW quarter, 2 = both channels moved at once.
  always_comb begin
    w_acc_next = r_acc;
    w_step     = 1'b0;
    w_dir      = DIR_CCW;
    w_err      = 1'b0;
    case (w_dq)
      2'd1: begin
        if (w_acc_inc == ACC_MAX) begin
          w_step     = 1'b1;
          w_dir      = DIR_CW;
          w_acc_next = '0;
        end else begin
          w_acc_next = w_acc_inc;
        end
      end
      2'd3: begin
        if (w_acc_dec == ACC_MIN) begin
          w_step     = 1'b1;
          w_dir      = DIR_CCW;
          w_acc_next = '0;
        end else begin
          w_acc_next = w_acc_dec;
        end
      end
      2'd2: begin
        w_err      = 1'b1;
        w_acc_next = '0;
      end
      default: w_acc_next = r_acc;
    endcase
  end

`ifdef ROT_ACCEL_EN
  localparam int WIN_W = $clog2(ACCEL_WIN + 2);
  localparam logic [WIN_W-1:0] WIN_SAT = WIN_W'(ACCEL_WIN + 1);
  localparam logic [WIN_W-1:0] WIN_MAX = WIN_W'(ACCEL_WIN);

  // r_win holds cycles since the last step; it starts saturated so the first step is never doubled.
  logic [WIN_W-1:0] r_win;

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_win <= WIN_SAT;
    end else if (w_step) begin
      r_win <= WIN_W'(1);
    end else if (r_win != WIN_SAT) begin
      r_win <= r_win + WIN_W'(1);
    end
  end

  assign w_delta = (r_win <= WIN_MAX) ? 2'd2 : 2'd1;
`else
  assign w_delta = 2'd1;
`endif

  assign w_pos_next = w_step ? POS_W'(next_pos(int'(pos), w_dir, int'(w_delta), N_LEDS, WRAP != 0))
                             : pos;

  always_comb begin
    w_light = '0;
    for (int i = 0; i < N_LEDS; i++) begin
      w_light[i] = (MODE == 0) ? (i == int'(w_pos_next)) : (i <= int'(w_pos_next));
    end
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_ab_prev  <= QS_00;
      r_acc      <= '0;
      pos        <= '0;
      light      <= N_LEDS'(1);
      step_valid <= 1'b0;
      step_dir   <= DIR_CCW;
      quad_err   <= 1'b0;
    end else begin
      r_ab_prev  <= quad_state_t'(w_ab);
      r_acc      <= w_acc_next;
      pos        <= w_pos_next;
      light      <= w_light;
      step_valid <= w_step;
      step_dir   <= w_step ? w_dir : DIR_CCW;
      if (w_err) quad_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_rot_position_bar.sv
// Directed bench for rot_position_bar: three instances (wrap/dot, saturate/dot,
// wrap/bar) share one encoder stimulus; ROT_ACCEL_EN enables the acceleration case.
module tb_rot_position_bar;

`ifdef ROT_ACCEL_EN
  localparam int AW = 25;
`else
  localparam int AW = 64;
`endif

  logic clk;
  logic nrst;
  logic rotA;
  logic rotB;

  logic [7:0] light_wrap, light_sat, light_bar;
  logic [2:0] pos_wrap, pos_sat, pos_bar;
  logic       sv_wrap, sv_sat, sv_bar;
  logic       sd_wrap, sd_sat, sd_bar;
  logic       qe_wrap, qe_sat, qe_bar;

  int n_checks = 0;
  int n_fail   = 0;
  int n_step_wrap = 0;
  int n_step_sat  = 0;
  logic last_dir_sat = 1'b1;

  rot_position_bar #(.N_LEDS(8), .DEB_CYCLES(4), .STEP_QUARTERS(4), .WRAP(1), .MODE(0),
                     .ACCEL_WIN(AW)) u_wrap (
    .clk(clk), .nrst(nrst), .rotA(rotA), .rotB(rotB), .light(light_wrap), .pos(pos_wrap),
    .step_valid(sv_wrap), .step_dir(sd_wrap), .quad_err(qe_wrap));

  rot_position_bar #(.N_LEDS(8), .DEB_CYCLES(4), .STEP_QUARTERS(4), .WRAP(0), .MODE(0),
                     .ACCEL_WIN(AW)) u_sat (
    .clk(clk), .nrst(nrst), .rotA(rotA), .rotB(rotB), .light(light_sat), .pos(pos_sat),
    .step_valid(sv_sat), .step_dir(sd_sat), .quad_err(qe_sat));

  rot_position_bar #(.N_LEDS(8), .DEB_CYCLES(4), .STEP_QUARTERS(4), .WRAP(1), .MODE(1),
                     .ACCEL_WIN(AW)) u_bar (
    .clk(clk), .nrst(nrst), .rotA(rotA), .rotB(rotB), .light(light_bar), .pos(pos_bar),
    .step_valid(sv_bar), .step_dir(sd_bar), .quad_err(qe_bar));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (sv_wrap === 1'b1) n_step_wrap++;
    if (sv_sat === 1'b1) begin
      n_step_sat++;
      last_dir_sat = sd_sat;
    end
  end

  // Every drive task returns 1 time unit after a rising edge.
  task automatic drive_ab(input logic [1:0] ab, input int hold);
    rotA = ab[1];
    rotB = ab[0];
    repeat (hold) @(posedge clk);
    #1;
  endtask

  task automatic detent(input logic cw, input int hold);
    if (cw) begin
      drive_ab(2'b01, hold); drive_ab(2'b11, hold); drive_ab(2'b10, hold); drive_ab(2'b00, hold);
    end else begin
      drive_ab(2'b10, hold); drive_ab(2'b11, hold); drive_ab(2'b01, hold); drive_ab(2'b00, hold);
    end
  endtask

  task automatic test_reset;
    nrst = 1'b0;
    rotA = 1'b0;
    rotB = 1'b0;
    for (int i = 0; i < 6; i++) begin
      rotA = i[0];
      rotB = i[1];
      @(posedge clk); #1;
    end
    n_checks += 6;
    if (light_wrap !== 8'h01) begin n_fail++; $display("FAIL reset_light: got %h want 01", light_wrap); end
    if (pos_wrap !== 3'd0) begin n_fail++; $display("FAIL reset_pos: got %0d want 0", pos_wrap); end
    if (sv_wrap !== 1'b0) begin n_fail++; $display("FAIL reset_step_valid: got %b want 0", sv_wrap); end
    if (qe_wrap !== 1'b0) begin n_fail++; $display("FAIL reset_quad_err: got %b want 0", qe_wrap); end
    if (light_bar !== 8'h01) begin n_fail++; $display("FAIL reset_light_bar: got %h want 01", light_bar); end
    if (sd_wrap !== 1'b0) begin n_fail++; $display("FAIL reset_step_dir: got %b want 0", sd_wrap); end
    rotA = 1'b0;
    rotB = 1'b0;
    repeat (3) @(posedge clk); #1;
    nrst = 1'b1;
    repeat (10) @(posedge clk); #1;
  endtask

  task automatic test_cw_latency;
    int base;
    base = n_step_wrap;
    drive_ab(2'b01, 10); drive_ab(2'b11, 10); drive_ab(2'b10, 10);
    n_checks++;
    if (n_step_wrap !== base) begin n_fail++; $display("FAIL cw_mid_detent_steps: got %0d want %0d", n_step_wrap, base); end
    rotA = 1'b0;
    rotB = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      @(posedge clk); #1;
      n_checks++;
      if (sv_wrap !== 1'(k == 7)) begin
        n_fail++; $display("FAIL cw_latency edge %0d: step_valid got %b want %b", k, sv_wrap, k == 7);
      end
      if (k == 7) begin
        n_checks += 4;
        if (sd_wrap !== 1'b1) begin n_fail++; $display("FAIL cw_dir: got %b want 1", sd_wrap); end
        if (pos_wrap !== 3'd1) begin n_fail++; $display("FAIL cw_pos: got %0d want 1", pos_wrap); end
        if (light_wrap !== 8'h02) begin n_fail++; $display("FAIL cw_light: got %h want 02", light_wrap); end
        if (light_bar !== 8'h03) begin n_fail++; $display("FAIL cw_light_bar: got %h want 03", light_bar); end
      end
    end
    repeat (2) @(posedge clk); #1;
    n_checks++;
    if (n_step_wrap !== base + 1) begin n_fail++; $display("FAIL cw_step_count: got %0d want %0d", n_step_wrap, base + 1); end
  endtask

  task automatic test_ccw_wrap;
    int bs;
    detent(1'b0, 10);
    n_checks += 3;
    if (pos_wrap !== 3'd0) begin n_fail++; $display("FAIL ccw_back_pos: got %0d want 0", pos_wrap); end
    if (pos_sat !== 3'd0) begin n_fail++; $display("FAIL ccw_back_pos_sat: got %0d want 0", pos_sat); end
    if (light_bar !== 8'h01) begin n_fail++; $display("FAIL ccw_back_light_bar: got %h want 01", light_bar); end
    bs = n_step_sat;
    detent(1'b0, 10);
    n_checks += 7;
    if (pos_wrap !== 3'd7) begin n_fail++; $display("FAIL ccw_wrap_pos: got %0d want 7", pos_wrap); end
    if (light_wrap !== 8'h80) begin n_fail++; $display("FAIL ccw_wrap_light: got %h want 80", light_wrap); end
    if (pos_sat !== 3'd0) begin n_fail++; $display("FAIL ccw_sat_pos: got %0d want 0", pos_sat); end
    if (light_sat !== 8'h01) begin n_fail++; $display("FAIL ccw_sat_light: got %h want 01", light_sat); end
    if (n_step_sat !== bs + 1) begin n_fail++; $display("FAIL ccw_sat_pulse: got %0d want %0d", n_step_sat, bs + 1); end
    if (last_dir_sat !== 1'b0) begin n_fail++; $display("FAIL ccw_sat_dir: got %b want 0", last_dir_sat); end
    if (light_bar !== 8'hFF) begin n_fail++; $display("FAIL ccw_wrap_light_bar: got %h want ff", light_bar); end
  endtask

  task automatic test_glitch;
    int b;
    b = n_step_wrap;
    rotA = 1'b1;
    repeat (3) @(posedge clk); #1;
    rotA = 1'b0;
    repeat (20) @(posedge clk); #1;
    n_checks += 2;
    if (n_step_wrap !== b) begin n_fail++; $display("FAIL glitch_steps: got %0d want %0d", n_step_wrap, b); end
    if (pos_wrap !== 3'd7) begin n_fail++; $display("FAIL glitch_pos: got %0d want 7", pos_wrap); end
    drive_ab(2'b01, 10); drive_ab(2'b11, 10); drive_ab(2'b01, 10); drive_ab(2'b00, 10);
    n_checks += 3;
    if (n_step_wrap !== b) begin n_fail++; $display("FAIL reversal_steps: got %0d want %0d", n_step_wrap, b); end
    if (pos_wrap !== 3'd7) begin n_fail++; $display("FAIL reversal_pos: got %0d want 7", pos_wrap); end
    if (qe_wrap !== 1'b0) begin n_fail++; $display("FAIL reversal_quad_err: got %b want 0", qe_wrap); end
    detent(1'b1, 10);
    n_checks++;
    if (pos_wrap !== 3'd0) begin n_fail++; $display("FAIL wrap_up_pos: got %0d want 0", pos_wrap); end
  endtask

  task automatic test_illegal;
    int b;
    b = n_step_wrap;
    drive_ab(2'b01, 10); drive_ab(2'b11, 10); drive_ab(2'b00, 10);
    n_checks += 3;
    if (qe_wrap !== 1'b1) begin n_fail++; $display("FAIL illegal_quad_err: got %b want 1", qe_wrap); end
    if (qe_sat !== 1'b1) begin n_fail++; $display("FAIL illegal_quad_err_sat: got %b want 1", qe_sat); end
    if (n_step_wrap !== b) begin n_fail++; $display("FAIL illegal_steps: got %0d want %0d", n_step_wrap, b); end
    drive_ab(2'b01, 10); drive_ab(2'b11, 10); drive_ab(2'b10, 10);
    n_checks++;
    if (n_step_wrap !== b) begin n_fail++; $display("FAIL illegal_acc_cleared: got %0d want %0d", n_step_wrap, b); end
    drive_ab(2'b00, 10);
    n_checks += 4;
    if (n_step_wrap !== b + 1) begin n_fail++; $display("FAIL post_illegal_steps: got %0d want %0d", n_step_wrap, b + 1); end
    if (pos_wrap !== 3'd1) begin n_fail++; $display("FAIL post_illegal_pos: got %0d want 1", pos_wrap); end
    if (pos_sat !== 3'd2) begin n_fail++; $display("FAIL post_illegal_pos_sat: got %0d want 2", pos_sat); end
    if (qe_wrap !== 1'b1) begin n_fail++; $display("FAIL quad_err_sticky: got %b want 1", qe_wrap); end
  endtask

  task automatic test_bar;
    detent(1'b0, 10);
    for (int i = 0; i < 3; i++) detent(1'b1, 10);
    n_checks += 4;
    if (light_bar !== 8'h0F) begin n_fail++; $display("FAIL bar_light: got %h want 0f", light_bar); end
    if (pos_bar !== 3'd3) begin n_fail++; $display("FAIL bar_pos: got %0d want 3", pos_bar); end
    if (light_wrap !== 8'h08) begin n_fail++; $display("FAIL dot_light: got %h want 08", light_wrap); end
    if (light_sat !== 8'h10) begin n_fail++; $display("FAIL dot_light_sat: got %h want 10", light_sat); end
  endtask

  task automatic test_saturate;
    int bs;
    bs = n_step_sat;
    for (int i = 0; i < 4; i++) detent(1'b1, 10);
    n_checks += 5;
    if (pos_sat !== 3'd7) begin n_fail++; $display("FAIL sat_top_pos: got %0d want 7", pos_sat); end
    if (light_sat !== 8'h80) begin n_fail++; $display("FAIL sat_top_light: got %h want 80", light_sat); end
    if (n_step_sat !== bs + 4) begin n_fail++; $display("FAIL sat_top_pulses: got %0d want %0d", n_step_sat, bs + 4); end
    if (pos_wrap !== 3'd7) begin n_fail++; $display("FAIL top_pos_wrap: got %0d want 7", pos_wrap); end
    if (light_bar !== 8'hFF) begin n_fail++; $display("FAIL top_light_bar: got %h want ff", light_bar); end
  endtask

`ifdef ROT_ACCEL_EN
  task automatic test_accel;
    detent(1'b1, 10);
    n_checks++;
    if (pos_wrap !== 3'd0) begin n_fail++; $display("FAIL accel_start_pos: got %0d want 0", pos_wrap); end
    repeat (40) @(posedge clk); #1;
    detent(1'b1, 5);
    drive_ab(2'b01, 5);
    n_checks++;
    if (pos_wrap !== 3'd1) begin n_fail++; $display("FAIL accel_first_pos: got %0d want 1", pos_wrap); end
    drive_ab(2'b11, 5); drive_ab(2'b10, 5); drive_ab(2'b00, 5);
    repeat (5) @(posedge clk); #1;
    n_checks += 3;
    if (pos_wrap !== 3'd3) begin n_fail++; $display("FAIL accel_second_pos: got %0d want 3", pos_wrap); end
    if (light_bar !== 8'h0F) begin n_fail++; $display("FAIL accel_light_bar: got %h want 0f", light_bar); end
    if (pos_sat !== 3'd7) begin n_fail++; $display("FAIL accel_sat_pos: got %0d want 7", pos_sat); end
  endtask
`endif

  initial begin
    test_reset();
    test_cw_latency();
    test_ccw_wrap();
    test_glitch();
    test_illegal();
    test_bar();
    test_saturate();
`ifdef ROT_ACCEL_EN
    test_accel();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
